// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead group per stage.
// Define CLA_SUB_EN to honour the per-operation sub flag; otherwise the block is add-only.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             ovf
);

  localparam int unsigned S = WIDTH / GROUP;

  if (GROUP == 0 || GROUP > 8 || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP, GROUP in 1..8");
  end

  // Flattened lookahead: every carry is a sum of products of g/p and the group carry-in.
  function automatic logic [GROUP:0] group_carries(input logic [GROUP-1:0] a,
                                                   input logic [GROUP-1:0] b,
                                                   input logic             cin);
    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;
    logic             term;
    g    = a & b;
    p    = a | b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(GROUP); i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  // Stage registers: stage k holds groups 0..k finished plus the carry out of group k.
  logic [S-1:0]     v_q;
  logic [WIDTH-1:0] a_q   [S];
  logic [WIDTH-1:0] b_q   [S];
  logic [WIDTH-1:0] sum_q [S];
  logic             c_q   [S];
  logic             ovf_q;
`ifdef CLA_SUB_EN
  logic             sub_q  [S];
  logic             up_sub [S];
`endif

  logic [WIDTH-1:0] up_a   [S];
  logic [WIDTH-1:0] up_b   [S];
  logic [WIDTH-1:0] up_sum [S];
  logic             up_c   [S];
  logic             up_v   [S];
  logic [WIDTH-1:0] sum_d  [S];
  logic             c_d    [S];
  logic             ovf_d;
  logic             cin0;
  logic [S-1:0]     rdy_c;

`ifdef CLA_SUB_EN
  assign cin0 = sub | CIN;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign cin0       = CIN;
`endif

  for (genvar gk = 0; gk < int'(S); gk++) begin : g_stage
    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic [GROUP:0]   gc;
    logic             gsub;

    if (gk == 0) begin : g_src_in
      assign up_a[gk]   = A;
      assign up_b[gk]   = B;
      assign up_sum[gk] = '0;
      assign up_c[gk]   = cin0;
      assign up_v[gk]   = in_valid;
`ifdef CLA_SUB_EN
      assign up_sub[gk] = sub;
`endif
    end else begin : g_src_prev
      assign up_a[gk]   = a_q[gk-1];
      assign up_b[gk]   = b_q[gk-1];
      assign up_sum[gk] = sum_q[gk-1];
      assign up_c[gk]   = c_q[gk-1];
      assign up_v[gk]   = v_q[gk-1];
`ifdef CLA_SUB_EN
      assign up_sub[gk] = sub_q[gk-1];
`endif
    end

`ifdef CLA_SUB_EN
    assign gsub = up_sub[gk];
`else
    assign gsub = 1'b0;
`endif

    // B is inverted group by group so the raw operand can travel unchanged.
    assign ga         = up_a[gk][gk*GROUP +: GROUP];
    assign gb         = up_b[gk][gk*GROUP +: GROUP] ^ {GROUP{gsub}};
    assign gc         = group_carries(ga, gb, up_c[gk]);
    assign c_d[gk]    = gc[GROUP];
    assign sum_d[gk]  = (up_sum[gk] & ~(WIDTH'({GROUP{1'b1}}) << (gk*GROUP)))
                      | (WIDTH'(ga ^ gb ^ gc[GROUP-1:0]) << (gk*GROUP));

    if (gk == int'(S) - 1) begin : g_ovf
      assign ovf_d = gc[GROUP] ^ gc[GROUP-1];
    end
  end

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    rdy_c      = '0;
    rdy_c[S-1] = !v_q[S-1] | out_ready;
    for (int i = int'(S) - 2; i >= 0; i--) begin
      rdy_c[i] = !v_q[i] | rdy_c[i+1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q   <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < int'(S); i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        sum_q[i] <= '0;
        c_q[i]   <= 1'b0;
`ifdef CLA_SUB_EN
        sub_q[i] <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < int'(S); i++) begin
        if (rdy_c[i]) begin
          v_q[i] <= up_v[i];
          if (up_v[i]) begin
            a_q[i]   <= up_a[i];
            b_q[i]   <= up_b[i];
            sum_q[i] <= sum_d[i];
            c_q[i]   <= c_d[i];
`ifdef CLA_SUB_EN
            sub_q[i] <= up_sub[i];
`endif
          end
        end
      end
      if (rdy_c[S-1] && up_v[S-1]) ovf_q <= ovf_d;
    end
  end

  assign in_ready  = !reset && rdy_c[0];
  assign out_valid = v_q[S-1];
  assign result    = {c_q[S-1], sum_q[S-1]};
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed vectors, decoupled output monitor.
module tb_pipelined_cla_adder;

  localparam int unsigned W = 16;
  localparam int unsigned G = 4;
  localparam int unsigned S = W / G;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         ovf;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    logic       ovf;
    int         acc;
    bit         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   stalls = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Monitor: pops the oldest expectation on every output transfer.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got result %0h, want no output", result);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, 32'(result), 32'(e.res));
        check({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
        if (e.lat) check({e.name, "_latency"}, 32'(cyc - e.acc), S);
      end
    end
  end

  task automatic send(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic s, input logic [W:0] res,
                      input logic ov, input bit lat);
    int   waits;
    exp_t e;
    A        = a;
    B        = b;
    CIN      = ci;
    sub      = s;
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got in_ready 0, want 1 within 50 cycles", name);
      in_valid = 1'b0;
    end else begin
      e.res  = res;
      e.ovf  = ov;
      e.acc  = cyc;
      e.lat  = lat;
      e.name = name;
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] st_a [10] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h00FF,
                              16'h0FFF, 16'hABCD, 16'hFFFF, 16'h4000, 16'h1357};
  logic [W-1:0] st_b [10] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h8000, 16'h0001,
                              16'h0001, 16'h1111, 16'h0000, 16'h4000, 16'h2468};
  logic         st_c [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [W:0]   st_r [10] = '{17'h00000, 17'h00001, 17'h1FFFF, 17'h10000, 17'h00100,
                              17'h01000, 17'h0BCDE, 17'h10000, 17'h08000, 17'h037C0};
  logic         st_o [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    CIN       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic vectors, each checked for exact latency on an empty pipeline.
    send("add_1234", 16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0, 1'b1);
    wait_drain("drain_basic1");
    send("add_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0, 1'b1);
    send("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 1'b1);
`ifdef CLA_SUB_EN
    send("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0, 1'b1);
    send("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1, 1'b1);
`else
    send("sub_ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0000C, 1'b0, 1'b1);
`endif
    wait_drain("drain_basic2");

    // Back-to-back stream at full throughput.
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      send($sformatf("stream%0d", i), st_a[i], st_b[i], st_c[i], 1'b0, st_r[i], st_o[i], 1'b1);
    end
    check("stream_stalls", 32'(stalls), 32'd0);
    wait_drain("drain_stream");

    // Backpressure: fill all stages, then release with a pending operation.
    out_ready = 1'b0;
    stalls    = 0;
    send("bp0", 16'h0001, 16'h0002, 1'b0, 1'b0, 17'h00003, 1'b0, 1'b0);
    send("bp1", 16'h0010, 16'h0020, 1'b0, 1'b0, 17'h00030, 1'b0, 1'b0);
    send("bp2", 16'h0100, 16'h0200, 1'b0, 1'b0, 17'h00300, 1'b0, 1'b0);
    send("bp3", 16'h1000, 16'h2000, 1'b1, 1'b0, 17'h03001, 1'b0, 1'b0);
    check("bp_fill_stalls", 32'(stalls), 32'd0);
    A        = 16'h7000;
    B        = 16'h7000;
    CIN      = 1'b0;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_full_in_ready", 32'(in_ready), 32'd0);
      check("bp_held_valid", 32'(out_valid), 32'd1);
      check("bp_held_result", 32'(result), 32'h00003);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    stalls    = 0;
    send("bp4", 16'h7000, 16'h7000, 1'b0, 1'b0, 17'h0E000, 1'b1, 1'b0);
    check("bp_release_stalls", 32'(stalls), 32'd0);
    wait_drain("drain_bp");

    // Reset with three operations in flight discards them all.
    send("rst0", 16'h1111, 16'h1111, 1'b0, 1'b0, 17'h02222, 1'b0, 1'b0);
    send("rst1", 16'h2222, 16'h2222, 1'b0, 1'b0, 17'h04444, 1'b0, 1'b0);
    send("rst2", 16'h3333, 16'h3333, 1'b0, 1'b0, 17'h06666, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_no_out_valid", 32'(out_valid), 32'd0);
      if (i == 0) check("rst_in_ready_high", 32'(in_ready), 32'd1);
    end
    @(posedge clk);
    #1;
    send("post_rst", 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 17'h10000, 1'b0, 1'b1);
    wait_drain("drain_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
